// File: rtl/seg_scan_ctrl_if.sv
// Pin-side bundle of the 7-segment scan controller.
// master drives the display request, slave drives the pins.
interface seg_scan_ctrl_if;
    logic        ENABLE;
    logic [15:0] DIGITS;
    logic [3:0]  DP_IN;
    logic [3:0]  AN;
    logic [6:0]  SEG;
    logic        DP;
    logic        SCAN_TICK;

    modport master (
        output ENABLE, DIGITS, DP_IN,
        input  AN, SEG, DP, SCAN_TICK
    );

    modport slave (
        input  ENABLE, DIGITS, DP_IN,
        output AN, SEG, DP, SCAN_TICK
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// 4-digit 7-segment scan scheduler with per-slot guard blanking.
// Optional: LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module seg_scan_ctrl #(
    parameter int DIV_MAX = 131071,
    parameter int GUARD   = 1024
) (
    input  logic           CLOCK,
    input  logic           RESET,
    seg_scan_ctrl_if.slave bus
);
    localparam int CW = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV_MAX);
    localparam logic [CW-1:0] GRD_LAST = CW'((GUARD > 0) ? GUARD - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GUARD,
        S_DRIVE
    } state_t;

    // With no guard gap a slot starts straight in DRIVE.
    localparam state_t SLOT_START = (GUARD == 0) ? S_DRIVE : S_GUARD;

    state_t        state, n_state;
    logic [CW-1:0] cnt, n_cnt;
    logic [1:0]    idx, n_idx;
    logic [15:0]   snap_dig, n_dig;
    logic [3:0]    snap_dp, n_dp;
    logic          n_tick;
    logic [3:0]    nib;
    logic          lz_blank;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        s = 7'h7F;
        unique case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Next-state: slot counter, digit index and frame snapshot.
    always_comb begin
        n_state = state;
        n_cnt   = cnt;
        n_idx   = idx;
        n_dig   = snap_dig;
        n_dp    = snap_dp;
        n_tick  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.ENABLE) begin
                    n_state = SLOT_START;
                    n_cnt   = '0;
                    n_idx   = 2'd0;
                    n_dig   = bus.DIGITS;
                    n_dp    = bus.DP_IN;
                    n_tick  = 1'b1;
                end
            end
            default: begin
                if (!bus.ENABLE) begin
                    n_state = S_IDLE;
                    n_cnt   = '0;
                    n_idx   = 2'd0;
                end else if (cnt == CNT_LAST) begin
                    n_state = SLOT_START;
                    n_cnt   = '0;
                    n_idx   = idx + 2'd1;
                    n_tick  = 1'b1;
                    // New frame: take the snapshot so it never tears.
                    if (idx == 2'd3) begin
                        n_dig = bus.DIGITS;
                        n_dp  = bus.DP_IN;
                    end
                end else begin
                    n_cnt = cnt + CW'(1);
                    if (state == S_GUARD && cnt == GRD_LAST)
                        n_state = S_DRIVE;
                end
            end
        endcase
    end

    assign nib = n_dig[{n_idx, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    // Digit k blanks when it and every digit above it are zero.
    always_comb begin
        lz_blank = 1'b0;
        unique case (n_idx)
            2'd3:    lz_blank = (n_dig[15:12] == 4'h0);
            2'd2:    lz_blank = (n_dig[15:8] == 8'h00);
            2'd1:    lz_blank = (n_dig[15:4] == 12'h000);
            default: lz_blank = 1'b0;
        endcase
    end
`else
    assign lz_blank = 1'b0;
`endif

    // State and pin registers; pins follow the next state.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state         <= S_IDLE;
            cnt           <= '0;
            idx           <= 2'd0;
            snap_dig      <= 16'h0000;
            snap_dp       <= 4'h0;
            bus.AN        <= 4'b1111;
            bus.SEG       <= 7'h7F;
            bus.DP        <= 1'b1;
            bus.SCAN_TICK <= 1'b0;
        end else begin
            state         <= n_state;
            cnt           <= n_cnt;
            idx           <= n_idx;
            snap_dig      <= n_dig;
            snap_dp       <= n_dp;
            bus.SCAN_TICK <= n_tick;
            if (n_state == S_DRIVE) begin
                bus.AN  <= ~(4'b0001 << n_idx);
                bus.SEG <= lz_blank ? 7'h7F : hex7(nib);
                bus.DP  <= ~n_dp[n_idx];
            end else begin
                bus.AN  <= 4'b1111;
                bus.SEG <= 7'h7F;
                bus.DP  <= 1'b1;
            end
        end
    end
endmodule
